// File: rtl/vector_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_cache_pkg
//  Purpose  : Shared types and constants for the vector cache write-response
//             path. Holds the write-response payload, the transaction id
//             carrying the direction index, the default response buffer
//             depth and a small direction-compare helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vector_cache_pkg;

    localparam int DIR_W           = 2;   // four directions
    localparam int TAG_W           = 6;
    localparam int SIDEBAND_W      = 8;
    localparam int WRESP_BUF_DEPTH = 8;

    typedef struct packed {
        logic [DIR_W-1:0] direction_id;
        logic [TAG_W-1:0] tag;
    } wr_txnid_t;

    typedef struct packed {
        wr_txnid_t             txnid;
        logic [SIDEBAND_W-1:0] sideband;
    } wr_resp_pld_t;

    // True when the response is addressed to direction 'dir'.
    function automatic logic dir_match(input wr_resp_pld_t pld,
                                       input logic [DIR_W-1:0] dir);
        return (pld.txnid.direction_id == dir);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vec_sync_fifo
//  Purpose  : Single-clock FIFO with extra-bit wrap pointers. Storage is not
//             reset; only the pointers are. Read data is the entry at the
//             read pointer (combinational), so it is valid the cycle after
//             the write that filled it.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             push, data_in - write strobe and data (ignored when full
//                             unless a pop happens in the same cycle)
//             pop, data_out - read strobe and head entry
//             empty, full   - status from the registered pointers
//             count         - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module vec_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam int c_cw = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;
    logic [c_pw-1:0]  w_diff;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts: write and read hit the same index on the same edge.
    assign w_do_push = push && (!full || w_do_pop);
    assign w_diff    = r_wr_ptr - r_rd_ptr;
    assign count     = c_cw'(w_diff);
    assign data_out  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wr_resp_dir_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wr_resp_dir_buffer
//  Purpose  : Per-direction write-response return buffer. Captures the
//             non-backpressured responses the decode stage sends to this
//             direction, queues them in order and returns them to the
//             master over valid/ready. Exports occupancy and an almost-full
//             credit throttle, and flags misdirected responses.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             in_vld, in_pld    - response from decode stage (never stalls)
//             out_vld, out_rdy,
//             out_pld           - head entry toward the master
//             almost_full       - free entries <= AF_MARGIN
//             count             - occupancy
//             dir_err           - sticky misdirected-response flag
//             ovf_err           - sticky overflow flag (WRESP_OVF_CHK_EN only)
//  Config   : WRESP_OVF_CHK_EN  - adds ovf_err and an overflow assertion;
//                                 without it overflowing responses are
//                                 silently dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module wr_resp_dir_buffer
    import vector_cache_pkg::*;
#(
    parameter int DIR_ID    = 0,
    parameter int DEPTH     = WRESP_BUF_DEPTH,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  wr_resp_pld_t               in_pld,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output wr_resp_pld_t               out_pld,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       dir_err
`ifdef WRESP_OVF_CHK_EN
    ,
    output logic                       ovf_err
`endif
);

    localparam int               c_cw        = $clog2(DEPTH+1);
    localparam logic [DIR_W-1:0] c_dir_id    = DIR_W'(DIR_ID);
    localparam logic [c_cw-1:0]  c_af_thresh = c_cw'(DEPTH - AF_MARGIN);

    logic w_match;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic r_dir_err;

    assign w_match = dir_match(in_pld, c_dir_id);
    assign out_vld = !w_empty;
    assign w_pop   = out_vld && out_rdy;
    assign w_push  = in_vld && w_match && (!w_full || w_pop);

    vec_sync_fifo #(
        .WIDTH ($bits(wr_resp_pld_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .data_in  (in_pld),
        .pop      (w_pop),
        .data_out (out_pld),
        .empty    (w_empty),
        .full     (w_full),
        .count    (count)
    );

    // Derived from registered occupancy: one cycle of credit lag, which the
    // AF_MARGIN covers for the decode stage's in-flight response.
    assign almost_full = (count >= c_af_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_err <= 1'b0;
        end else if (in_vld && !w_match) begin
            r_dir_err <= 1'b1;
        end
    end
    assign dir_err = r_dir_err;

`ifdef WRESP_OVF_CHK_EN
    logic w_ovf;
    logic r_ovf_err;

    // Full and no pop: the matching response has nowhere to go.
    assign w_ovf = in_vld && w_match && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (w_ovf) begin
            r_ovf_err <= 1'b1;
        end
    end
    assign ovf_err = r_ovf_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!w_ovf)
                else $warning("wr_resp_dir_buffer: response overflow, entry dropped");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_resp_dir_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wr_resp_dir_buffer
//  Purpose  : Scoreboard bench for wr_resp_dir_buffer (DIR_ID=2, DEPTH=8,
//             AF_MARGIN=2). Stimulus pushes expected payloads into a queue;
//             a monitor compares the head whenever out_vld is presented.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wr_resp_dir_buffer;
    import vector_cache_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_vld;
    wr_resp_pld_t in_pld;
    logic         out_vld;
    logic         out_rdy;
    wr_resp_pld_t out_pld;
    logic         almost_full;
    logic [3:0]   count;
    logic         dir_err;
`ifdef WRESP_OVF_CHK_EN
    logic         ovf_err;
`endif

    int total = 0;
    int bad   = 0;
    wr_resp_pld_t exp_q[$];

    wr_resp_dir_buffer #(
        .DIR_ID    (2),
        .DEPTH     (8),
        .AF_MARGIN (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_pld      (in_pld),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_pld     (out_pld),
        .almost_full (almost_full),
        .count       (count),
        .dir_err     (dir_err)
`ifdef WRESP_OVF_CHK_EN
        ,
        .ovf_err     (ovf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wr_resp_pld_t mk(input logic [1:0] dir,
                                        input logic [5:0] tag,
                                        input logic [7:0] sb);
        wr_resp_pld_t p;
        p.txnid.direction_id = dir;
        p.txnid.tag          = tag;
        p.sideband           = sb;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one matching response that the bench expects to be accepted.
    task automatic send(input logic [5:0] tag, input logic [7:0] sb);
        in_vld = 1'b1;
        in_pld = mk(2'd2, tag, sb);
        exp_q.push_back(in_pld);
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_rdy = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d left want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every presented head must equal the oldest expected entry,
    // and it leaves the queue only when the handshake completes.
    always @(negedge clk) begin
        if (!rst && out_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got 0x%0h want no output", out_pld);
            end else begin
                if (out_pld !== exp_q[0]) begin
                    bad++;
                    $display("FAIL out_pld: got 0x%0h want 0x%0h", out_pld, exp_q[0]);
                end
                if (out_rdy) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_pld  = '0;
        out_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_dir_err", 32'(dir_err), 32'd0);
`ifdef WRESP_OVF_CHK_EN
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
`endif

        // Single response: visible only one cycle after the push
        out_rdy = 1'b1;
        send(6'd0, 8'h5A);
        @(negedge clk);
        check("no_bypass", 32'(out_vld), 32'd0);
        tick();
        in_vld = 1'b0;
        check("single_vld", 32'(out_vld), 32'd1);
        check("single_count", 32'(count), 32'd1);
        tick();
        check("single_count_after", 32'(count), 32'd0);
        check("single_vld_after", 32'(out_vld), 32'd0);

        // Fill with out_rdy low; almost_full rises on the 6th push
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(6'(i), 8'(8'h10 + i));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        in_vld = 1'b0;

        // Simultaneous push and pop while full
        send(6'd8, 8'h18);
        out_rdy = 1'b1;
        tick();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        check("pp_full_count", 32'(count), 32'd8);
        check("pp_full_af", 32'(almost_full), 32'd1);
`ifdef WRESP_OVF_CHK_EN
        check("pp_full_ovf", 32'(ovf_err), 32'd0);
`endif

        // Overflow: matching push while full, no pop -> dropped
        in_vld = 1'b1;
        in_pld = mk(2'd2, 6'd9, 8'h99);
        tick();
        in_vld = 1'b0;
        check("ovf_count", 32'(count), 32'd8);
`ifdef WRESP_OVF_CHK_EN
        check("ovf_set", 32'(ovf_err), 32'd1);
        tick();
        check("ovf_held", 32'(ovf_err), 32'd1);
`endif

        // In-order drain (tags 1..8); the dropped tag 9 must never appear
        drain("drain1");
        tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_vld", 32'(out_vld), 32'd0);

        // Misdirected responses are dropped and flagged
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_pld  = mk(2'd3, 6'd30, 8'hC3);
        tick();
        in_pld  = mk(2'd0, 6'd31, 8'hC0);
        tick();
        in_vld = 1'b0;
        check("mis_dir_err", 32'(dir_err), 32'd1);
        check("mis_count", 32'(count), 32'd0);
        check("mis_out_vld", 32'(out_vld), 32'd0);
        tick();
        check("mis_dir_err_held", 32'(dir_err), 32'd1);

        // Reset mid-drain with a coinciding push
        for (int i = 0; i < 5; i++) begin
            send(6'(20 + i), 8'(8'h40 + i));
            tick();
        end
        in_vld = 1'b0;
        check("pre_rst_count", 32'(count), 32'd5);
        rst     = 1'b1;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_pld  = mk(2'd2, 6'd50, 8'hEE);
        exp_q.delete();
        tick();
        rst    = 1'b0;
        in_vld = 1'b0;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_dir_err", 32'(dir_err), 32'd0);
        check("mid_rst_af", 32'(almost_full), 32'd0);
        tick();
        check("mid_rst_push_ignored", 32'(count), 32'd0);

        // Back-to-back streaming with out_rdy high
        out_rdy = 1'b1;
        send(6'd40, 8'hA0);
        tick();
        send(6'd41, 8'hA1);
        tick();
        send(6'd42, 8'hA2);
        tick();
        send(6'd43, 8'hA3);
        tick();
        in_vld = 1'b0;
        check("stream_count", 32'(count), 32'd1);
        drain("drain2");
        tick();
        check("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
